cv32e40p_cdec_ft_monitor: RTL and testbench

CV32E40P_CDEC_FT_MONITOR -- requirements
Module: cv32e40p_cdec_ft_monitor

---
 rtl/cv32e40p_cdec_ft_monitor.sv | 124 ++++++++++++
 tb/tb_cv32e40p_cdec_ft_monitor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_cdec_ft_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cv32e40p_cdec_ft_monitor : per-replica error counters and TMR/DMR/FAIL mode
//                             tracking for the triplicated compressed decoder.
// Optional macro CDEC_FT_CNT_OBS_EN exposes the counters on cnt_o.
// Revision: 1.0
// ----------------------------------------------------------------------------
module cv32e40p_cdec_ft_monitor #(
  parameter int unsigned DECREMENT          = 1,
  parameter int unsigned INCREMENT          = 1,
  parameter int unsigned BREAKING_THRESHOLD = 3,
  parameter int unsigned COUNT_BIT          = 8,
  parameter int unsigned INC_DEC_BIT        = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic [2:0]               err_i,
  input  logic                     clear_i,
  output logic [2:0]               broken_o,
  output logic [1:0]               mode_o,
  output logic [1:0]               excl_o,
  output logic                     fault_o
`ifdef CDEC_FT_CNT_OBS_EN
  ,
  output logic [3*COUNT_BIT-1:0]   cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_TMR  = 2'b00,
    ST_DMR  = 2'b01,
    ST_FAIL = 2'b10
  } state_e;

  localparam int unsigned             CW      = COUNT_BIT + 1;
  localparam logic [INC_DEC_BIT-1:0]  INC_OP  = INC_DEC_BIT'(INCREMENT);
  localparam logic [INC_DEC_BIT-1:0]  DEC_OP  = INC_DEC_BIT'(DECREMENT);
  localparam logic [COUNT_BIT:0]      INC_EXT = CW'(INC_OP);
  localparam logic [COUNT_BIT:0]      DEC_EXT = CW'(DEC_OP);
  localparam logic [COUNT_BIT:0]      THR     = CW'(BREAKING_THRESHOLD);
  localparam logic [COUNT_BIT-1:0]    CNT_MAX = '1;

  logic [2:0][COUNT_BIT-1:0] cnt_q;
  logic [2:0][COUNT_BIT-1:0] cnt_d;
  logic [2:0]                broken_q;
  logic [2:0]                new_brk;
  state_e                    state_q;
  logic [1:0]                excl_q;
  logic                      fault_q;

  // One extra bit of headroom makes carry-out and borrow directly visible.
  for (genvar k = 0; k < 3; k++) begin : g_cnt
    logic [COUNT_BIT:0] sum;
    logic [COUNT_BIT:0] diff;

    assign sum  = {1'b0, cnt_q[k]} + INC_EXT;
    assign diff = {1'b0, cnt_q[k]} - DEC_EXT;

    assign cnt_d[k] = (!valid_i || broken_q[k]) ? cnt_q[k] :
                      err_i[k] ? (sum[COUNT_BIT]  ? CNT_MAX : sum[COUNT_BIT-1:0]) :
                                 (diff[COUNT_BIT] ? '0      : diff[COUNT_BIT-1:0]);

    assign new_brk[k] = !broken_q[k] && ({1'b0, cnt_d[k]} >= THR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      broken_q <= 3'b000;
      state_q  <= ST_TMR;
      excl_q   <= 2'b11;
      fault_q  <= 1'b0;
    end else if (clear_i) begin
      cnt_q    <= '0;
      broken_q <= 3'b000;
      state_q  <= ST_TMR;
      excl_q   <= 2'b11;
      fault_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      broken_q <= broken_q | new_brk;
      fault_q  <= 1'b0;
      case (state_q)
        ST_TMR: begin
          case (new_brk)
            3'b000: ;
            3'b001: begin state_q <= ST_DMR; excl_q <= 2'd0; fault_q <= 1'b1; end
            3'b010: begin state_q <= ST_DMR; excl_q <= 2'd1; fault_q <= 1'b1; end
            3'b100: begin state_q <= ST_DMR; excl_q <= 2'd2; fault_q <= 1'b1; end
            default: begin
              state_q <= ST_FAIL;
              excl_q  <= 2'b11;
              fault_q <= 1'b1;
            end
          endcase
        end
        ST_DMR: begin
          if (|new_brk) begin
            state_q <= ST_FAIL;
            excl_q  <= 2'b11;
            fault_q <= 1'b1;
          end
        end
        ST_FAIL: ;
        default: begin
          state_q <= ST_FAIL;
          excl_q  <= 2'b11;
        end
      endcase
    end
  end

  assign broken_o = broken_q;
  assign mode_o   = state_q;
  assign excl_o   = excl_q;
  assign fault_o  = fault_q;

`ifdef CDEC_FT_CNT_OBS_EN
  assign cnt_o = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_cdec_ft_monitor.sv
`default_nettype none
// Scoreboard bench for cv32e40p_cdec_ft_monitor: the driver queues hand-computed
// expectations per cycle, a monitor pops and compares them after each edge.
module tb_cv32e40p_cdec_ft_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid_i = 1'b0;
  logic [2:0] err_i = 3'b000;
  logic       clear_i = 1'b0;
  logic [2:0] broken_o;
  logic [1:0] mode_o;
  logic [1:0] excl_o;
  logic       fault_o;

  typedef struct {
    logic [2:0] brk;
    logic [1:0] mode;
    logic [1:0] excl;
    logic       flt;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  cv32e40p_cdec_ft_monitor dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .err_i    (err_i),
    .clear_i  (clear_i),
    .broken_o (broken_o),
    .mode_o   (mode_o),
    .excl_o   (excl_o),
    .fault_o  (fault_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    chk({tag, ".broken"}, 32'(broken_o),        32'(e.brk));
    chk({tag, ".mode"},   32'(mode_o),          32'(e.mode));
    chk({tag, ".excl"},   32'(excl_o),          32'(e.excl));
    chk({tag, ".fault"},  32'(fault_o),         32'(e.flt));
    chk({tag, ".cnt0"},   32'(dut.cnt_q[0]),    32'(e.c0));
    chk({tag, ".cnt1"},   32'(dut.cnt_q[1]),    32'(e.c1));
    chk({tag, ".cnt2"},   32'(dut.cnt_q[2]),    32'(e.c2));
  endtask

  // Drive one cycle of stimulus and queue what the outputs must be after its edge.
  task automatic step(input logic v, input logic [2:0] e, input logic c,
                      input logic [2:0] brk, input logic [1:0] mode, input logic [1:0] excl,
                      input logic flt, input int c0, input int c1, input int c2);
    exp_t x;
    @(negedge clk);
    valid_i = v;
    err_i   = e;
    clear_i = c;
    x.brk = brk; x.mode = mode; x.excl = excl; x.flt = flt;
    x.c0 = 8'(c0); x.c1 = 8'(c1); x.c2 = 8'(c2);
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp_all("step", e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  exp_t rst_exp;

  initial begin : driver
    rst_exp.brk = 3'b000; rst_exp.mode = 2'b00; rst_exp.excl = 2'b11; rst_exp.flt = 1'b0;
    rst_exp.c0 = 8'd0; rst_exp.c1 = 8'd0; rst_exp.c2 = 8'd0;

    #1 rst = 1'b1;
    #2 cmp_all("reset", rst_exp);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Replica 0 breaks after three errors: TMR -> DMR, excl 0.
    step(1, 3'b001, 0, 3'b000, 2'b00, 2'b11, 0, 1, 0, 0);
    step(1, 3'b001, 0, 3'b000, 2'b00, 2'b11, 0, 2, 0, 0);
    step(1, 3'b001, 0, 3'b001, 2'b01, 2'b00, 1, 3, 0, 0);
    step(0, 3'b000, 0, 3'b001, 2'b01, 2'b00, 0, 3, 0, 0);
    step(0, 3'b000, 1, 3'b000, 2'b00, 2'b11, 0, 0, 0, 0);

    // Up/down counting of replica 1 below threshold, with floor at zero.
    step(1, 3'b010, 0, 3'b000, 2'b00, 2'b11, 0, 0, 1, 0);
    step(1, 3'b010, 0, 3'b000, 2'b00, 2'b11, 0, 0, 2, 0);
    step(1, 3'b000, 0, 3'b000, 2'b00, 2'b11, 0, 0, 1, 0);
    step(1, 3'b000, 0, 3'b000, 2'b00, 2'b11, 0, 0, 0, 0);
    step(1, 3'b010, 0, 3'b000, 2'b00, 2'b11, 0, 0, 1, 0);
    step(1, 3'b010, 0, 3'b000, 2'b00, 2'b11, 0, 0, 2, 0);
    step(0, 3'b000, 1, 3'b000, 2'b00, 2'b11, 0, 0, 0, 0);

    // Two replicas break together: TMR -> FAIL directly; FAIL is terminal.
    step(1, 3'b011, 0, 3'b000, 2'b00, 2'b11, 0, 1, 1, 0);
    step(1, 3'b011, 0, 3'b000, 2'b00, 2'b11, 0, 2, 2, 0);
    step(1, 3'b011, 0, 3'b011, 2'b10, 2'b11, 1, 3, 3, 0);
    step(0, 3'b000, 0, 3'b011, 2'b10, 2'b11, 0, 3, 3, 0);
    step(1, 3'b100, 0, 3'b011, 2'b10, 2'b11, 0, 3, 3, 1);
    step(0, 3'b000, 1, 3'b000, 2'b00, 2'b11, 0, 0, 0, 0);

    // Replica 2 breaks (DMR, excl 2), then replica 0 breaks: DMR -> FAIL.
    step(1, 3'b100, 0, 3'b000, 2'b00, 2'b11, 0, 0, 0, 1);
    step(1, 3'b100, 0, 3'b000, 2'b00, 2'b11, 0, 0, 0, 2);
    step(1, 3'b100, 0, 3'b100, 2'b01, 2'b10, 1, 0, 0, 3);
    step(1, 3'b001, 0, 3'b100, 2'b01, 2'b10, 0, 1, 0, 3);
    step(1, 3'b001, 0, 3'b100, 2'b01, 2'b10, 0, 2, 0, 3);
    step(1, 3'b001, 0, 3'b101, 2'b10, 2'b11, 1, 3, 0, 3);
    step(0, 3'b000, 0, 3'b101, 2'b10, 2'b11, 0, 3, 0, 3);

    // Clear wins over a simultaneous all-error update while in FAIL.
    step(1, 3'b111, 1, 3'b000, 2'b00, 2'b11, 0, 0, 0, 0);
    step(0, 3'b000, 0, 3'b000, 2'b00, 2'b11, 0, 0, 0, 0);

    // Reach DMR on replica 1; its counter must stay frozen afterwards.
    step(1, 3'b010, 0, 3'b000, 2'b00, 2'b11, 0, 0, 1, 0);
    step(1, 3'b010, 0, 3'b000, 2'b00, 2'b11, 0, 0, 2, 0);
    step(1, 3'b010, 0, 3'b010, 2'b01, 2'b01, 1, 0, 3, 0);
    step(1, 3'b010, 0, 3'b010, 2'b01, 2'b01, 0, 0, 3, 0);
    step(0, 3'b000, 0, 3'b010, 2'b01, 2'b01, 0, 0, 3, 0);

    // Asynchronous reset mid-cycle while in DMR.
    @(posedge clk);
    #3 rst = 1'b1;
    #1 cmp_all("async_rst", rst_exp);
    @(negedge clk);
    rst = 1'b0;

    // Counting resumes on the first edge after reset release.
    step(1, 3'b001, 0, 3'b000, 2'b00, 2'b11, 0, 1, 0, 0);
    step(0, 3'b000, 0, 3'b000, 2'b00, 2'b11, 0, 1, 0, 0);

    for (int i = 0; i < 8 && sb.size() > 0; i++) @(posedge clk);
    #3;
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
